// File: rtl/cms_pix28_package.sv
// Shared definitions for the CMS pixel-28 command path: op-code map, field
// positions inside the SW command word and the op-code decoder FSM states.
package cms_pix28_package;

    // Field positions inside fw_op_code_w_reg
    localparam int unsigned op_code_index_min          = 0;
    localparam int unsigned op_code_index_max          = 4;
    localparam int unsigned op_code_index_trigger      = 5;
    localparam int unsigned op_code_index_test_sel_min = 6;
    localparam int unsigned op_code_index_test_sel_max = 7;

    // Command map; values 0x10..0x1F are illegal
    typedef enum logic [4:0] {
        OP_NOP             = 5'h00,
        OP_STATUS_CLEAR    = 5'h01,
        OP_W_RESET         = 5'h02,
        OP_W_CFG_STATIC_0  = 5'h03,
        OP_R_CFG_STATIC_0  = 5'h04,
        OP_W_CFG_STATIC_1  = 5'h05,
        OP_R_CFG_STATIC_1  = 5'h06,
        OP_W_CFG_ARRAY_0   = 5'h07,
        OP_R_CFG_ARRAY_0   = 5'h08,
        OP_W_CFG_ARRAY_1   = 5'h09,
        OP_R_CFG_ARRAY_1   = 5'h0A,
        OP_W_CFG_ARRAY_2   = 5'h0B,
        OP_R_CFG_ARRAY_2   = 5'h0C,
        OP_R_DATA_ARRAY_0  = 5'h0D,
        OP_R_DATA_ARRAY_1  = 5'h0E,
        OP_W_EXECUTE       = 5'h0F
    } op_code_t;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_DECODE,
        ST_STROBE,
        ST_WAIT_DONE
    } op_code_dec_state_t;

    // One-hot strobe vector for a legal (4-bit) op-code
    function automatic logic [15:0] op_code_onehot(input logic [3:0] idx);
        op_code_onehot = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/com_timeout_cnt.sv
// Cycle counter for WAIT_DONE supervision: load clears it, enable counts up,
// and it stops at MAX where expired_o stays high until the next load.
// Only instantiated when COM_OP_CODE_TIMEOUT_EN is defined.
module com_timeout_cnt #(
    parameter int unsigned    W   = 24,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q;

    assign expired_o = (cnt_q == MAX);

    // Counter register: clear on load, count while enabled, hold at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/com_op_code_decoder.sv
// Op-code decoder: turns each toggle of the SW trigger bit into a one-cycle
// op-code strobe, gates w_execute on configuration completeness, supervises
// the selected test state machine and keeps sticky error flags.
// Optional feature macro: COM_OP_CODE_TIMEOUT_EN (WAIT_DONE timeout).
module com_op_code_decoder
    import cms_pix28_package::*;
#(
    parameter int unsigned          TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 24'hFF_FFFF
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst_n,
    input  logic [31:0] fw_op_code_w_reg,
    input  logic [3:0]  sm_test_o_status_done,
    output logic [15:0] op_code_strobe,
    output logic [1:0]  op_code_test_sel,
    output logic        busy,
    output logic        error_w_execute_cfg,
    output logic        error_op_code_illegal,
    output logic        error_overrun,
    output logic        error_timeout
);

    op_code_dec_state_t state_q, state_d;
    logic        trig_q;
    logic        trig_toggle;
    logic [4:0]  op_q, op_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  test_sel_q, test_sel_d;
    logic [15:0] strobe_q, strobe_d;
    logic        cfg_s0_q, cfg_s0_d;
    logic        cfg_s1_q, cfg_s1_d;
    logic        err_cfg_q, err_cfg_d;
    logic        err_ill_q, err_ill_d;
    logic        err_ovr_q, err_ovr_d;
    logic        unused_cmd_bits;

    assign trig_toggle     = fw_op_code_w_reg[op_code_index_trigger] ^ trig_q;
    assign unused_cmd_bits = ^fw_op_code_w_reg[31:8];

`ifdef COM_OP_CODE_TIMEOUT_EN
    logic err_tmo_q, err_tmo_d;
    logic tmo_expired;
    logic tmo_load;

    // Restart the count on every entry into WAIT_DONE
    assign tmo_load = (state_q == ST_STROBE) && (state_d == ST_WAIT_DONE);

    com_timeout_cnt #(
        .W   (TIMEOUT_W),
        .MAX (TIMEOUT_MAX)
    ) u_timeout_cnt (
        .clk       (fw_axi_clk),
        .rst_n     (fw_rst_n),
        .load_i    (tmo_load),
        .en_i      (state_q == ST_WAIT_DONE),
        .expired_o (tmo_expired)
    );

    assign error_timeout = err_tmo_q;
`else
    assign error_timeout = 1'b0;
`endif

    // Next-state and register-update logic for the command FSM
    always_comb begin
        // NOTE: every signal gets its default before the case so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        op_d       = op_q;
        sel_d      = sel_q;
        test_sel_d = test_sel_q;
        strobe_d   = '0;
        cfg_s0_d   = cfg_s0_q;
        cfg_s1_d   = cfg_s1_q;
        err_cfg_d  = err_cfg_q;
        err_ill_d  = err_ill_q;
        err_ovr_d  = err_ovr_q;
`ifdef COM_OP_CODE_TIMEOUT_EN
        err_tmo_d  = err_tmo_q;
`endif

        case (state_q)
            ST_ARM: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (trig_toggle) begin
                    op_d    = fw_op_code_w_reg[op_code_index_max:op_code_index_min];
                    sel_d   = fw_op_code_w_reg[op_code_index_test_sel_max:op_code_index_test_sel_min];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_q[4]) begin
                    err_ill_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (op_q == OP_NOP) begin
                    state_d = ST_IDLE;
                end else if ((op_q == OP_W_EXECUTE) && !(cfg_s0_q && cfg_s1_q)) begin
                    err_cfg_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    strobe_d = op_code_onehot(op_q[3:0]);
                    if (op_q == OP_W_EXECUTE) begin
                        test_sel_d = sel_q;
                    end
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (op_q == OP_STATUS_CLEAR) begin
                    err_cfg_d = 1'b0;
                    err_ill_d = 1'b0;
                    err_ovr_d = 1'b0;
`ifdef COM_OP_CODE_TIMEOUT_EN
                    err_tmo_d = 1'b0;
`endif
                end
                if (op_q == OP_W_RESET) begin
                    cfg_s0_d = 1'b0;
                    cfg_s1_d = 1'b0;
                end
                if (op_q == OP_W_CFG_STATIC_0) begin
                    cfg_s0_d = 1'b1;
                end
                if (op_q == OP_W_CFG_STATIC_1) begin
                    cfg_s1_d = 1'b1;
                end
                state_d = (op_q == OP_W_EXECUTE) ? ST_WAIT_DONE : ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (sm_test_o_status_done[sel_q]) begin
                    state_d = ST_IDLE;
                end
`ifdef COM_OP_CODE_TIMEOUT_EN
                else if (tmo_expired) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase

        // A toggle outside IDLE is dropped; flagged after the clear so a
        // coincident status_clear cannot hide it
        if (trig_toggle && (state_q != ST_IDLE)) begin
            err_ovr_d = 1'b1;
        end
    end

    // State and datapath registers; trig_q tracks the trigger bit every cycle
    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q    <= ST_ARM;
            trig_q     <= 1'b0;
            op_q       <= '0;
            sel_q      <= '0;
            test_sel_q <= '0;
            strobe_q   <= '0;
            cfg_s0_q   <= 1'b0;
            cfg_s1_q   <= 1'b0;
            err_cfg_q  <= 1'b0;
            err_ill_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
`ifdef COM_OP_CODE_TIMEOUT_EN
            err_tmo_q  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            trig_q     <= fw_op_code_w_reg[op_code_index_trigger];
            op_q       <= op_d;
            sel_q      <= sel_d;
            test_sel_q <= test_sel_d;
            strobe_q   <= strobe_d;
            cfg_s0_q   <= cfg_s0_d;
            cfg_s1_q   <= cfg_s1_d;
            err_cfg_q  <= err_cfg_d;
            err_ill_q  <= err_ill_d;
            err_ovr_q  <= err_ovr_d;
`ifdef COM_OP_CODE_TIMEOUT_EN
            err_tmo_q  <= err_tmo_d;
`endif
        end
    end

    assign op_code_strobe        = strobe_q;
    assign op_code_test_sel      = test_sel_q;
    assign busy                  = (state_q != ST_IDLE);
    assign error_w_execute_cfg   = err_cfg_q;
    assign error_op_code_illegal = err_ill_q;
    assign error_overrun         = err_ovr_q;

endmodule

// File: tb/tb_com_op_code_decoder.sv
// Directed bench for com_op_code_decoder: stimulus pushes expected strobes
// into a scoreboard queue, a negedge monitor pops and compares them.
module tb_com_op_code_decoder;

    typedef struct {
        logic [15:0] strobe;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] op_reg;
    logic [3:0]  done;
    logic [15:0] strobe;
    logic [1:0]  test_sel;
    logic        busy;
    logic        err_cfg;
    logic        err_ill;
    logic        err_ovr;
    logic        err_tmo;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];

    com_op_code_decoder #(
        .TIMEOUT_W   (24),
        .TIMEOUT_MAX (24'd100)
    ) dut (
        .fw_axi_clk            (clk),
        .fw_rst_n              (rst_n),
        .fw_op_code_w_reg      (op_reg),
        .sm_test_o_status_done (done),
        .op_code_strobe        (strobe),
        .op_code_test_sel      (test_sel),
        .busy                  (busy),
        .error_w_execute_cfg   (err_cfg),
        .error_op_code_illegal (err_ill),
        .error_overrun         (err_ovr),
        .error_timeout         (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: any nonzero strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (strobe !== 16'h0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {16'h0, strobe}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_value", {16'h0, strobe}, {16'h0, e.strobe});
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    // Flip the trigger bit with a new op/test_sel
    task automatic toggle(input logic [4:0] op, input logic [1:0] sel);
        logic t;
        t = ~op_reg[5];
        op_reg = {24'h0, sel, t, op};
    endtask

    // Issue a command, optionally expect a strobe two cycles later, then let it settle
    task automatic issue(input logic [4:0] op, input logic [1:0] sel,
                         input bit has_exp, input logic [15:0] exp_strobe);
        exp_t e;
        toggle(op, sel);
        if (has_exp) begin
            e.strobe = exp_strobe;
            e.cyc    = cyc + 2;
            sb_q.push_back(e);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        op_reg = 32'h0000_0020;
        done   = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",     {31'h0, busy},     32'h1);
        check("rst_strobe",   {16'h0, strobe},   32'h0);
        check("rst_test_sel", {30'h0, test_sel}, 32'h0);
        check("rst_err_cfg",  {31'h0, err_cfg},  32'h0);
        check("rst_err_ill",  {31'h0, err_ill},  32'h0);
        check("rst_err_ovr",  {31'h0, err_ovr},  32'h0);
        check("rst_err_tmo",  {31'h0, err_tmo},  32'h0);

        // Release with trigger high: ARM absorbs it, IDLE after one cycle
        rst_n = 1'b1;
        @(negedge clk);
        check("arm_busy_low", {31'h0, busy}, 32'h0);
        repeat (20) @(negedge clk);
        check("arm_idle_busy", {31'h0, busy}, 32'h0);

        // w_cfg_static_0
        issue(5'h03, 2'd0, 1'b1, 16'h0008);
        // Execute with only cfg_s0: rejected
        issue(5'h0F, 2'd0, 1'b0, 16'h0);
        check("exec_cfg_err", {31'h0, err_cfg}, 32'h1);
        // status_clear clears errors
        issue(5'h01, 2'd0, 1'b1, 16'h0002);
        check("clr_err_cfg", {31'h0, err_cfg}, 32'h0);
        check("clr_err_ovr", {31'h0, err_ovr}, 32'h0);

        // w_cfg_static_1 then execute on test 3 (sel = 2)
        issue(5'h05, 2'd0, 1'b1, 16'h0020);
        done = 4'b1011;
        issue(5'h0F, 2'd2, 1'b1, 16'h8000);
        check("exec_test_sel", {30'h0, test_sel}, 32'h2);
        check("wait_busy", {31'h0, busy}, 32'h1);
        repeat (10) @(negedge clk);
        check("wait_busy_hold", {31'h0, busy}, 32'h1);
        check("wait_ovr_pre", {31'h0, err_ovr}, 32'h0);
        toggle(5'h01, 2'd2);
        repeat (2) @(negedge clk);
        check("wait_overrun", {31'h0, err_ovr}, 32'h1);
        check("wait_busy_ovr", {31'h0, busy}, 32'h1);
        done = 4'b0100;
        @(negedge clk);
        check("wait_exit", {31'h0, busy}, 32'h0);
        done = 4'b0000;
        @(negedge clk);

        // w_reset clears config; test_sel holds
        issue(5'h02, 2'd1, 1'b1, 16'h0004);
        check("test_sel_hold", {30'h0, test_sel}, 32'h2);
        issue(5'h0F, 2'd1, 1'b0, 16'h0);
        check("exec_after_wreset", {31'h0, err_cfg}, 32'h1);

        // Illegal boundary 0x10
        issue(5'h10, 2'd0, 1'b0, 16'h0);
        check("illegal_0x10", {31'h0, err_ill}, 32'h1);
        issue(5'h01, 2'd0, 1'b1, 16'h0002);
        check("clr_all_ill", {31'h0, err_ill}, 32'h0);
        check("clr_all_cfg", {31'h0, err_cfg}, 32'h0);
        check("clr_all_ovr", {31'h0, err_ovr}, 32'h0);
        issue(5'h15, 2'd0, 1'b0, 16'h0);
        check("illegal_0x15", {31'h0, err_ill}, 32'h1);
        check("illegal_no_cfg", {31'h0, err_cfg}, 32'h0);

        // NOP: no strobe, back to idle
        issue(5'h00, 2'd0, 1'b0, 16'h0);
        check("nop_idle", {31'h0, busy}, 32'h0);

        // Second toggle one cycle later is dropped as overrun
        begin
            exp_t e;
            toggle(5'h04, 2'd0);
            e.strobe = 16'h0010;
            e.cyc    = cyc + 2;
            sb_q.push_back(e);
            @(negedge clk);
            toggle(5'h04, 2'd0);
            repeat (4) @(negedge clk);
            check("b2b_overrun", {31'h0, err_ovr}, 32'h1);
            check("b2b_idle", {31'h0, busy}, 32'h0);
        end

        // Reset in WAIT_DONE aborts to ARM and drops configuration
        issue(5'h03, 2'd0, 1'b1, 16'h0008);
        issue(5'h05, 2'd0, 1'b1, 16'h0020);
        issue(5'h0F, 2'd1, 1'b1, 16'h8000);
        check("pre_abort_sel", {30'h0, test_sel}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'h1);
        check("abort_test_sel", {30'h0, test_sel}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_idle", {31'h0, busy}, 32'h0);
        issue(5'h0F, 2'd1, 1'b0, 16'h0);
        check("abort_cfg_cleared", {31'h0, err_cfg}, 32'h1);

        // Done already high on entry: one cycle in WAIT_DONE
        issue(5'h03, 2'd0, 1'b1, 16'h0008);
        issue(5'h05, 2'd0, 1'b1, 16'h0020);
        done = 4'b0001;
        issue(5'h0F, 2'd0, 1'b1, 16'h8000);
        check("done_hi_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        check("done_hi_exit", {31'h0, busy}, 32'h0);
        done = 4'b0000;
        @(negedge clk);

`ifdef COM_OP_CODE_TIMEOUT_EN
        // Timeout: done held low, expires at cycle 100 of WAIT_DONE
        begin
            int k;
            k = -1;
            issue(5'h0F, 2'd3, 1'b1, 16'h8000);
            for (int i = 1; i <= 300; i++) begin
                @(negedge clk);
                if (err_tmo && k < 0) k = i;
                if (k >= 0) break;
            end
            check("timeout_cycle", k, 101);
            check("timeout_idle", {31'h0, busy}, 32'h0);
        end
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
